// File: rtl/irq_ctrl.sv
// Interrupt request collector: synchronises, edge-detects, masks and priority-encodes irq lines.
// Optional macro IRQ_LEVEL_EN selects level-sensitive (non-sticky) pending instead of edge capture.
//
// state | meaning
// IDLE  | no request presented; latches cause when an enabled pending bit exists
// REQ   | inter asserted, cause frozen, waiting for take
// SVC   | handler running, cause frozen, waiting for iret
// RSVD  | unreachable encoding, behaves as IDLE
module irq_ctrl #(
    parameter int NIRQ = 8,
    parameter int IDXW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NIRQ-1:0] irq,
    input  logic            take,
    input  logic            iret,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            inter,
    output logic [IDXW-1:0] cause,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2,
        RSVD = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [NIRQ-1:0] sync1, sync2, enable, act, pend_view;
    logic [IDXW-1:0] cause_r, enc;
    logic            latch_cause, cause_act, w_en;

    assign w_en = we && (addr == 2'd0);
    assign act  = pend_view & enable;

`ifdef IRQ_LEVEL_EN
    // Level mode: pending simply mirrors the synchronised line.
    assign pend_view = sync2;
`else
    logic [NIRQ-1:0] sync3, pending, rise, clr;
    logic            take_ok, w_pend;

    assign take_ok   = (state == REQ) && take;
    assign w_pend    = we && (addr == 2'd1);
    assign rise      = sync2 & ~sync3;
    assign pend_view = pending;

    // A new edge on the serviced line outlives both W1C and the take auto-clear.
    always_comb begin
        clr = w_pend ? wdata[NIRQ-1:0] : '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (take_ok && (cause_r == IDXW'(i))) clr[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync3   <= '0;
            pending <= '0;
        end else begin
            sync3   <= sync2;
            pending <= (pending & ~clr) | rise;
        end
    end
`endif

    always_comb begin
        enc = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (act[i]) enc = IDXW'(i);
        end
    end

    always_comb begin
        cause_act = 1'b0;
        for (int i = 0; i < NIRQ; i++) begin
            if (cause_r == IDXW'(i)) cause_act = act[i];
        end
    end

    always_comb begin
        state_nxt   = state;
        latch_cause = 1'b0;
        inter       = 1'b0;
        busy        = 1'b0;
        case (state)
            REQ: begin
                inter = 1'b1;
                busy  = 1'b1;
                if (take) state_nxt = SVC;
                else if (!cause_act) state_nxt = IDLE;
            end
            SVC: begin
                busy = 1'b1;
                if (iret) state_nxt = IDLE;
            end
            default: begin
                if (|act) begin
                    state_nxt   = REQ;
                    latch_cause = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            enable  <= '0;
            cause_r <= '0;
            state   <= IDLE;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
            if (w_en) enable <= wdata[NIRQ-1:0];
            if (latch_cause) cause_r <= enc;
            state <= state_nxt;
        end
    end

    assign cause = cause_r;

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata[NIRQ-1:0] = enable;
            2'd1: rdata[NIRQ-1:0] = pend_view;
            2'd2: begin
                rdata[31]         = busy;
                rdata[IDXW-1:0]   = cause_r;
            end
            default: rdata[1:0] = state;
        endcase
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt request collector upstream of the pipeline interrupt/exception unit.
- Synchronises up to NIRQ external request lines, edge-detects them into a pending register, gates them with a software enable mask, and priority-encodes them.
- Drives the single interrupt-request level into the interrupt unit and holds a stable cause for the handler.
- Software reaches enable/pending/cause through a small word-addressed register port.

Parameters:
- NIRQ, 8, number of external request lines (1..32).
- IDXW, 5, width of the cause index field.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- irq  input  NIRQ  asynchronous external request lines.
- take  input  1  one-cycle pulse: the interrupt unit has vectored to the interrupt handler.
- iret  input  1  one-cycle pulse: return-from-interrupt executed.
- we  input  1  register write strobe.
- addr  input  2  register select.
- wdata  input  32  write data.
- rdata  output  32  read data (combinational from addr).
- inter  output  1  interrupt request level to the interrupt unit.
- cause  output  IDXW  index of the request being serviced.
- busy  output  1  high in REQ or SVC.

Behaviour:
- Reset (rst_n=0 at clk edge): sync flops, edge flops, pending, enable, cause all 0; state IDLE; inter=0; busy=0.
- Input path:
  - Two-flop synchroniser per line, then a third flop for edge detect.
  - Rising edge sets the pending bit.
  - Latency from irq rise to pending set: 3 clocks.
- Registers:
  - addr 0 ENABLE: RW, bits [NIRQ-1:0]; upper bits read 0.
  - addr 1 PENDING: read; write-1-to-clear.
  - addr 2 CAUSE: read {busy, 26'b0, cause}.
  - addr 3 STATUS: read {30'b0, state}; writes ignored.
- Same-cycle set and clear of one pending bit: set wins.
- Active vector act = pending & enable. Priority: lowest set index wins.
- FSM states (2-bit encoding):
  - IDLE (0): inter=0. If act!=0, latch cause = encode(act) and go to REQ.
  - REQ (1): inter=1; cause frozen.
    - take -> SVC; the pending bit [cause] auto-clears that cycle, unless a new edge on the same line arrives in the same cycle.
    - Else if act[cause]==0 (software cleared or disabled it) -> IDLE with inter dropping next cycle.
  - SVC (2): inter=0; cause frozen. iret -> IDLE.
  - State 3 is unreachable; treat it as IDLE.
- take outside REQ and iret outside SVC are ignored.
- From IDLE, the next request asserts inter no earlier than 1 clock after entry, so at least one low cycle separates services.
- Reset mid-operation (any state) returns everything to reset values; pending requests are lost.
- NIRQ<32: bits above NIRQ-1 are ignored on write and read 0.

Optional Feature:
- Macro IRQ_LEVEL_EN.
- Defined: pending is not stored. Pending reads as the synchronised level (2-clock latency). W1C writes to PENDING have no effect and the take auto-clear is skipped. REQ->IDLE when the level drops.
- Undefined: edge-triggered sticky pending as described above.

Test Plan:
- Reset then irq[3] rise with ENABLE=0x08 -> PENDING=0x08 after 3 clocks; inter=1 and cause=3 one clock later; rdata at addr 2 = 0x80000003.
- irq[5] and irq[2] rise together, ENABLE=0xFF -> cause=2. take -> inter=0, PENDING=0x20. iret -> IDLE, then inter=1, cause=5.
- In REQ with cause=4, write PENDING=0x10 -> state IDLE next clock; inter=0; cause register unchanged until the next request.
- irq[1] edge coinciding with the take cycle for cause=1 -> PENDING bit1 stays 1; after iret, inter re-asserts with cause=1.
- ENABLE=0x00 with irq[0] edge -> PENDING=0x01, inter stays 0. Write ENABLE=0x01 -> inter=1 within 2 clocks.
- rst_n low for one clock while in SVC -> all outputs and registers 0, STATUS=0. Also: a take pulse in IDLE is ignored (no state change).
